display_arbiter: RTL and testbench

Time-slicing arbiter that shares the board's single 4-digit seven-segment display between up to four 16-bit requesters, such as the CPU output port, PC trace and debug registers. It sits between those sources and the `hex_display` driver and supplies the 16-bit value plus blanking and source-indication controls. Arbitration is round-robin with a fixed dwell time per source, an optional blank gap between sources, and a lock input that freezes the current source.

---
 rtl/display_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_display_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : display_arbiter
// Purpose  : Round-robin time-slicing arbiter sharing one 4-digit seven-
//            segment display between up to four 16-bit sources. Each granted
//            source is shown for a fixed dwell, optionally separated from a
//            different source by a blank gap; lock freezes the current owner.
// Ports    : clk       - system clock, rising edge
//            rst_n     - asynchronous active-low reset
//            req[3:0]  - per-source request level
//            src_data  - four packed 16-bit source values (source i at 16*i)
//            lock      - freeze dwell counter and keep current source
//            data      - registered value for the hex display driver
//            blank     - blank all digits
//            grant     - one-hot current owner (zero when none)
//            dp        - decimal-point mask, mirrors grant
//            done      - one-cycle pulse when a source completes a full dwell
// Revision : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int unsigned DWELL = 50_000_000,
    parameter int unsigned BLANK = 5_000_000,
    parameter int unsigned CW    = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [63:0] src_data,
    input  logic        lock,
    output logic [15:0] data,
    output logic        blank,
    output logic [3:0]  grant,
    output logic [3:0]  dp,
    output logic [3:0]  done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LOAD = (BLANK > 0) ? CW'(BLANK - 1) : '0;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q,   ptr_d;
    logic [1:0]    next_q,  next_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [15:0]   data_q,  data_d;
    logic          blank_q, blank_d;
    logic [3:0]    grant_q, grant_d;
    logic [3:0]    done_q,  done_d;

    logic          win_found;
    logic [1:0]    win_idx;
    logic          end_dwell;

    // Round-robin search starting just after the last granted index and
    // wrapping back to it last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!win_found && req[ptr_q + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        next_d    = next_q;
        cnt_d     = cnt_q;
        done_d    = '0;
        end_dwell = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_SHOW;
                    ptr_d   = win_idx;
                    cnt_d   = DWELL_LOAD;
                end
            end

            ST_SHOW: begin
                // A dropped request ends the dwell even under lock, and a
                // simultaneous expiry is treated as an early release.
                if (!req[ptr_q]) begin
                    end_dwell = 1'b1;
                end else if (!lock) begin
                    if (cnt_q == '0) begin
                        end_dwell     = 1'b1;
                        done_d[ptr_q] = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                if (end_dwell) begin
                    if (!win_found) begin
                        state_d = ST_IDLE;
                    end else if (win_idx == ptr_q) begin
                        // Sole requester continues without a gap.
                        cnt_d = DWELL_LOAD;
                    end else if (BLANK == 0) begin
                        ptr_d = win_idx;
                        cnt_d = DWELL_LOAD;
                    end else begin
                        state_d = ST_BLANK;
                        cnt_d   = BLANK_LOAD;
                        next_d  = win_idx;
                    end
                end
            end

            ST_BLANK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (req[next_q]) begin
                    state_d = ST_SHOW;
                    ptr_d   = next_q;
                    cnt_d   = DWELL_LOAD;
                end else if (win_found) begin
                    // Pending source gave up during the gap: re-search from
                    // the last owner.
                    state_d = ST_SHOW;
                    ptr_d   = win_idx;
                    cnt_d   = DWELL_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are derived from the next state so they are registered
    // alongside it.
    always_comb begin
        blank_d = (state_d != ST_SHOW);
        grant_d = (state_d == ST_SHOW) ? (4'b0001 << ptr_d) : 4'b0000;
        data_d  = (state_d == ST_SHOW) ? src_data[{ptr_d, 4'b0000} +: 16] : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd3;
            next_q  <= 2'd0;
            cnt_q   <= '0;
            data_q  <= 16'h0000;
            blank_q <= 1'b1;
            grant_q <= 4'b0000;
            done_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            next_q  <= next_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign data  = data_q;
    assign blank = blank_q;
    assign grant = grant_q;
    assign dp    = grant_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_arbiter
// Purpose  : Self-checking bench for display_arbiter (DWELL=4, BLANK=2).
//            A cycle-level reference model pushes the expected outputs after
//            every rising edge; a monitor pops and compares on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int CW    = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [3:0]  req      = 4'b0000;
    logic [63:0] src_data = 64'h0;
    logic        lock     = 1'b0;
    logic [15:0] data;
    logic        blank;
    logic [3:0]  grant;
    logic [3:0]  dp;
    logic [3:0]  done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_arbiter #(
        .DWELL (DWELL),
        .BLANK (BLANK),
        .CW    (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .src_data (src_data),
        .lock     (lock),
        .data     (data),
        .blank    (blank),
        .grant    (grant),
        .dp       (dp),
        .done     (done)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        blank;
        logic [3:0]  grant;
        logic [3:0]  done;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = nothing shown, 1 = showing owner, 2 = gap before pend.
    // left counts the cycles still to be spent in the current mode,
    // including the present one.
    int          m_mode  = 0;
    int          m_owner = 0;
    int          m_last  = 3;
    int          m_pend  = 0;
    int          m_left  = 0;
    logic [15:0] m_data  = 16'h0;
    logic [3:0]  m_done  = 4'h0;

    function automatic int pick(input int from, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_owner = 0; m_last = 3; m_pend = 0; m_left = 0;
        m_data = 16'h0; m_done = 4'h0;
    endtask

    task automatic m_start(input int w);
        m_mode = 1; m_owner = w; m_last = w; m_left = DWELL;
    endtask

    task automatic m_release(input logic [3:0] r);
        int w;
        w = pick(m_last, r);
        if (w < 0)                 m_mode = 0;
        else if (w == m_owner)     m_left = DWELL;
        else if (BLANK == 0)       m_start(w);
        else begin
            m_mode = 2; m_pend = w; m_left = BLANK;
        end
    endtask

    task automatic m_step(input logic [3:0] r, input logic lk, input logic [63:0] src);
        int w;
        m_done = 4'h0;
        if (m_mode == 0) begin
            w = pick(m_last, r);
            if (w >= 0) m_start(w);
        end else if (m_mode == 1) begin
            if (!r[m_owner]) m_release(r);
            else if (!lk) begin
                if (m_left == 1) begin
                    m_done[m_owner] = 1'b1;
                    m_release(r);
                end else begin
                    m_left--;
                end
            end
        end else begin
            if (m_left > 1) m_left--;
            else if (r[m_pend]) m_start(m_pend);
            else begin
                w = pick(m_last, r);
                if (w >= 0) m_start(w);
                else m_mode = 0;
            end
        end
        if (m_mode == 1) m_data = src[m_owner*16 +: 16];
    endtask

    always @(negedge rst_n) begin
        m_reset();
        exp_q.delete();
    end

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) m_reset();
        else        m_step(req, lock, src_data);
        e.data  = m_data;
        e.blank = (m_mode != 1);
        e.grant = (m_mode == 1) ? (4'b0001 << m_owner) : 4'b0000;
        e.done  = m_done;
        exp_q.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data",  data,          e.data);
            check("blank", {15'h0, blank}, {15'h0, e.blank});
            check("grant", {12'h0, grant}, {12'h0, e.grant});
            check("dp",    {12'h0, dp},    {12'h0, e.grant});
            check("done",  {12'h0, done},  {12'h0, e.done});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data,           16'h0000);
        check({tag, "_blank"}, {15'h0, blank}, 16'h0001);
        check({tag, "_grant"}, {12'h0, grant}, 16'h0000);
        check({tag, "_dp"},    {12'h0, dp},    16'h0000);
        check({tag, "_done"},  {12'h0, done},  16'h0000);
    endtask

    initial begin
        // 1: reset, idle, first request latency
        tick(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(10);
        src_data[15:0] = 16'h1234;
        req = 4'b0001;
        tick(1);
        check("lat_grant", {12'h0, grant}, 16'h0001);
        check("lat_dp",    {12'h0, dp},    16'h0001);
        check("lat_data",  data,           16'h1234);
        check("lat_blank", {15'h0, blank}, 16'h0000);
        tick(3);

        // 2: two requesters alternate with a gap
        src_data = 64'hDDDD_CCCC_BBBB_AAAA;
        req = 4'b0101;
        tick(30);

        // 3: single requester, continuous grant
        req = 4'b0010;
        tick(20);

        // 4: lock holds source 0 while its data changes
        req = 4'b0001;
        tick(4);
        req = 4'b0011;
        lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            src_data[15:0] = 16'($urandom);
            tick(1);
        end
        lock = 1'b0;
        tick(12);

        // 5: early release on source 2, then pending source drops in gap
        req = 4'b0000;
        tick(8);
        req = 4'b0100;
        tick(2);
        req = 4'b1000;
        tick(8);
        req = 4'b0000;
        tick(8);
        req = 4'b0100;
        tick(2);
        req = 4'b1000;
        tick(1);
        req = 4'b0000;
        tick(6);

        // 6: asynchronous reset mid-SHOW and mid-BLANK
        req = 4'b1111;
        tick(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst_show");
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("first_grant", {12'h0, grant}, 16'h0001);
        tick(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("arst_blank");
        tick(2);
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int s;
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(15) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(19) == 0) lock = ~lock;
            if ($urandom_range(3) == 0) begin
                s = int'($urandom_range(3));
                src_data[s*16 +: 16] = 16'($urandom);
            end
        end
        lock = 1'b0;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
